// File: rtl/raw2gray_pkg.sv
// Shared types for the Bayer-RAW to grayscale stream reducer.
package raw2gray_pkg;

  // Reduction mode applied to each 2x2 quad; code 3 behaves as average.
  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_GREEN = 2'd1,
    MODE_MAX   = 2'd2
  } mode_e;

  // Colour filter array layout, named by the top-left quad row.
  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_e;

  // Frame tracking state.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // True when the two green samples sit on the P00/P11 diagonal of the quad.
  function automatic logic greens_on_diagonal(input bayer_e cfa);
    return (cfa == BAYER_GRBG) || (cfa == BAYER_GBRG);
  endfunction

endpackage

// File: rtl/raw_line_buf.sv
// Single-port line memory: combinational read of the old word at addr,
// with the new word written on the same clock when we is set.
module raw_line_buf #(
  parameter int PIX_W  = 12,
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read returns the word stored before this cycle's write.
  assign rdata = mem[addr];

  // Store the incoming pixel so the next line can read it back as "above".
  // NOTE: the data array has no reset; stale contents are never consumed
  // because the first line of a frame completes no quad.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/raw2gray_stream.sv
// Bayer-RAW raster stream to grayscale reducer: one gray pixel per 2x2 quad,
// with quad coordinates, border flag, end-of-frame and resync indications.
module raw2gray_stream
  import raw2gray_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int IMG_W = 1280,
  parameter int IMG_H = 960,
  parameter int BAYER = 0,
  parameter int COL_W = 16,
  parameter int ROW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  output logic [COL_W-2:0] out_col,
  output logic [ROW_W-2:0] out_row,
  output logic             out_edge,
  output logic             frame_done,
  output logic             err_sync
);

  localparam int                 AW        = $clog2(IMG_W);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-2:0]   LAST_QCOL = (COL_W-1)'(IMG_W / 2 - 1);
  localparam logic [ROW_W-2:0]   LAST_QROW = (ROW_W-1)'(IMG_H / 2 - 1);
  localparam bayer_e             CFA       = bayer_e'(BAYER[1:0]);
  localparam logic               GREEN_DIAG = greens_on_diagonal(CFA);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;

  logic             sof_in, accept, mid_sof, last_pix, quad_done;
  logic [PIX_W-1:0] above_pix, prev_pix, prev_above;
  logic [PIX_W-1:0] p00, p01, p10, p11;
  logic [PIX_W+1:0] sum4;
  logic [PIX_W:0]   sum2;
  logic [PIX_W-1:0] max_top, max_bot, max_all, gray;
  logic [COL_W-2:0] qcol;
  logic [ROW_W-2:0] qrow;

  // Qualify the incoming pixel and resolve its raster coordinates;
  // an accepted sof always restarts the frame at (0,0).
  always_comb begin
    sof_in    = in_valid & in_sof;
    accept    = in_valid & (sof_in | (state_q == ACTIVE));
    cur_col   = sof_in ? '0 : col_q;
    cur_row   = sof_in ? '0 : row_q;
    last_pix  = (cur_col == LAST_COL) && (cur_row == LAST_ROW);
    mid_sof   = sof_in && (state_q == ACTIVE) && ((col_q != '0) || (row_q != '0));
    quad_done = accept & cur_col[0] & cur_row[0];
    qcol      = cur_col[COL_W-1:1];
    qrow      = cur_row[ROW_W-1:1];
  end

  // Next-state, counter and mode-latch logic.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE:   if (sof_in) state_d = ACTIVE;
      ACTIVE: if (accept && last_pix && !sof_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (sof_in) mode_d = mode_e'(mode);
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  // State, counters and latched mode.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_AVG;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  raw_line_buf #(
    .PIX_W (PIX_W),
    .DEPTH (IMG_W),
    .ADDR_W(AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (accept),
    .addr (cur_col[AW-1:0]),
    .wdata(in_pixel),
    .rdata(above_pix)
  );

  // Hold the left-hand column of the quad taps (current and above).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pix   <= '0;
      prev_above <= '0;
    end else if (accept) begin
      prev_pix   <= in_pixel;
      prev_above <= above_pix;
    end
  end

  // Reduce the quad according to the mode latched at start of frame.
  always_comb begin
    p00     = prev_above;
    p01     = above_pix;
    p10     = prev_pix;
    p11     = in_pixel;
    sum4    = {2'b00, p00} + {2'b00, p01} + {2'b00, p10} + {2'b00, p11};
    sum2    = GREEN_DIAG ? ({1'b0, p00} + {1'b0, p11}) : ({1'b0, p01} + {1'b0, p10});
    max_top = (p00 > p01) ? p00 : p01;
    max_bot = (p10 > p11) ? p10 : p11;
    max_all = (max_top > max_bot) ? max_top : max_bot;
    case (mode_q)
      MODE_GREEN: gray = sum2[PIX_W:1];
      MODE_MAX:   gray = max_all;
      default:    gray = sum4[PIX_W+1:2];
    endcase
  end

  // Registered result stream; payload holds between quads, pulses last 1 cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      out_edge   <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      err_sync <= mid_sof;
      if (quad_done) begin
        out_pixel  <= gray;
        out_valid  <= 1'b1;
        out_col    <= qcol;
        out_row    <= qrow;
        out_edge   <= (qcol == '0) || (qcol == LAST_QCOL) ||
                      (qrow == '0) || (qrow == LAST_QROW);
        frame_done <= (qcol == LAST_QCOL) && (qrow == LAST_QROW);
      end else begin
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/raw2gray_stream.md
Name: raw2gray_stream

Overview:
Parametrised second-generation Bayer-RAW to grayscale reducer. It takes one raster RAW pixel per valid cycle and generates its own column and row counters from a start-of-frame marker. Each 2x2 Bayer quad is reduced to one gray pixel using a selectable mode: average, green-only or maximum. Each output carries its quad coordinates, an edge flag and an end-of-frame pulse. It sits between the sensor capture interface and the downstream gray-image consumers.

Parameters:
PIX_W, 12, RAW and gray pixel width in bits
IMG_W, 1280, input pixels per line; even, >= 4
IMG_H, 960, input lines per frame; even, >= 4
BAYER, 0, CFA layout: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
COL_W, 16, width of the internal column counter; must satisfy 2^COL_W > IMG_W
ROW_W, 16, width of the internal row counter; must satisfy 2^ROW_W > IMG_H

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_pixel  in  PIX_W  RAW pixel
in_valid  in  1  in_pixel valid this cycle
in_sof  in  1  qualified by in_valid; marks pixel (0,0)
mode  in  2  0 avg, 1 green, 2 max, 3 = avg; sampled on an accepted sof
out_pixel  out  PIX_W  gray result
out_valid  out  1  out_pixel valid
out_col  out  COL_W-1  quad column (input col >> 1)
out_row  out  ROW_W-1  quad row (input row >> 1)
out_edge  out  1  quad lies on the image border
frame_done  out  1  pulse with the last quad of a frame
err_sync  out  1  pulse on sof received mid-frame

Behaviour:
- Reset (async, active-low): state IDLE; counters 0; mode_q 0; all outputs 0. Line-buffer contents are don't-care.
- FSM IDLE:
  - in_valid & in_sof: accept the pixel as (0,0), latch mode_q, go to ACTIVE.
  - in_valid without sof: pixel dropped, no output.
- FSM ACTIVE:
  - Each in_valid pixel is accepted; col increments and wraps at IMG_W-1, at which point row increments.
  - After pixel (IMG_W-1, IMG_H-1) is accepted, return to IDLE.
- Mid-frame sof (in_valid & in_sof in ACTIVE while col/row != 0/0):
  - err_sync pulses for 1 cycle.
  - The pixel becomes (0,0) of a new frame and mode_q is re-latched.
  - No output is produced for the abandoned partial quad.
- Back-to-back frames: a sof on the cycle after the last pixel has been accepted is normal and raises no error.
- Quad taps:
  - Line buffer, depth IMG_W, read-before-write at address col; it yields the pixel directly above.
  - Registers hold the previous current pixel and the previous above-pixel.
  - Quad naming: P00 (top-left), P01 (top-right), P10 (bottom-left), P11 (bottom-right).
- A quad completes on the accepted pixel with odd col and odd row.
- Arithmetic:
  - avg: (P00+P01+P10+P11) computed at PIX_W+2 bits, then >>2 (truncate).
  - green: (Ga+Gb) computed at PIX_W+1 bits, then >>1. Ga/Gb = P01/P10 for RGGB/BGGR; P00/P11 for GRBG/GBRG.
  - max: largest of the four quad pixels.
  - No saturation is required; results always fit in PIX_W bits.
- Latency: out_valid and all out_* are registered. They assert exactly 1 cycle after the completing pixel is accepted, for 1 cycle. Otherwise out_valid=0 and the other outputs hold their last values.
- out_edge = (out_col==0) | (out_col==IMG_W/2-1) | (out_row==0) | (out_row==IMG_H/2-1).
- frame_done = out_valid for quad (IMG_W/2-1, IMG_H/2-1).
- Gaps in in_valid stall everything; no state advances and no timeout applies.
- mode changes mid-frame are ignored until the next accepted sof.

Decomposition:
- raw2gray_pkg: mode enum (MODE_AVG, MODE_GREEN, MODE_MAX); bayer enum; state enum (IDLE, ACTIVE).
- Sub-module raw_line_buf: parametrised PIX_W x DEPTH single-port read-before-write memory with write enable. No reset on the data array.

Test Plan:
All scenarios use PIX_W=12, IMG_W=8, IMG_H=4, BAYER=0.
- Frame 0..31 with quad (0,0) = 100,200 / 600,400, mode 0 → out_pixel 325 at out_col0/row0, 1 cycle after pixel index 9; 8 outputs total; out_edge=1 on all; frame_done with the last output.
- Same quad, mode 1 → 400; mode 2 → 600; all four pixels = 4095, mode 0 → 4095 (no wrap).
- Pixels sent before any sof, and with random in_valid gaps → ignored before sof; after sof the outputs are identical to the gap-free run, shifted in time.
- sof on pixel 13 of a frame → err_sync 1-cycle pulse, coordinates restart at 0/0, next full frame correct; back-to-back sof after the last pixel raises no err_sync.
- rst asserted mid-frame → all outputs 0 immediately, state IDLE; following frame correct; mode changed mid-frame is not applied until the next sof.
- BAYER=1, green mode, quad 100,200 / 600,400 → (100+400)>>1 = 250.
